hazard_ctrl: RTL and testbench

Pipeline hazard and stall scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Inputs: register-use and writeback fields decoded in ID, branch/jump redirects resolved in EX, and the data-memory handshake in MEM.
- Outputs: per-stage stall/flush enables and EX operand forwarding selects.
- Keeps its own shadow copy of the destination-register fields for EX, MEM and WB, so no pipeline-register taps are needed.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_fwd_sel.sv | 37 +++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared encodings for the RV32I hazard/stall scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_fwd_sel
// Brief    : Forwarding source select for one EX operand (MEM beats WB).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_fwd_sel #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic            rs_use,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regw,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regw,
  output logic [1:0]      sel
);
  import hazard_ctrl_pkg::*;

  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hardwired zero, so a write to it never supplies a value
  assign w_mem_hit = rs_use && mem_regw && (mem_rd != '0) && (mem_rd == rs);
  assign w_wb_hit  = rs_use && wb_regw  && (wb_rd  != '0) && (wb_rd  == rs);

  always_comb begin
    sel = FWD_RF;
    if (w_mem_hit) begin
      sel = FWD_MEM;
    end else if (w_wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush scheduler and EX forwarding control for a 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_mem2reg,
  input  logic            ex_redirect,
  input  logic            mem_req,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            stall_mem,
  output logic            flush_id,
  output logic            flush_ex,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            dmem_timeout
);
  import hazard_ctrl_pkg::*;

  logic [RA_W-1:0]   r_ex_rd, r_ex_rs1, r_ex_rs2, r_mem_rd, r_wb_rd;
  logic              r_ex_rs1_use, r_ex_rs2_use, r_ex_regw, r_ex_ld;
  logic              r_mem_regw, r_mem_ld, r_wb_regw;
  hz_state_e         r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic              w_freeze, w_load_use, w_bubble;

  assign w_freeze   = mem_req && !mem_ack;
  assign w_load_use = r_ex_ld && r_ex_regw && (r_ex_rd != '0) &&
                      ((id_rs1_use && (id_rs1 == r_ex_rd)) ||
                       (id_rs2_use && (id_rs2 == r_ex_rd)));
  assign w_bubble   = ex_redirect || w_load_use;
  assign dmem_timeout = r_timeout;

  hazard_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .rs(r_ex_rs1), .rs_use(r_ex_rs1_use),
    .mem_rd(r_mem_rd), .mem_regw(r_mem_regw),
    .wb_rd(r_wb_rd), .wb_regw(r_wb_regw),
    .sel(fwd_a)
  );

  hazard_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .rs(r_ex_rs2), .rs_use(r_ex_rs2_use),
    .mem_rd(r_mem_rd), .mem_regw(r_mem_regw),
    .wb_rd(r_wb_rd), .wb_regw(r_wb_regw),
    .sel(fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stall/flush terms are gated by rst_n so nothing leaks out during reset
  always_comb begin
    w_state_nxt = r_state;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    case (r_state)
      HZ_RUN:      if (w_freeze) w_state_nxt = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (mem_ack)  w_state_nxt = HZ_RUN;
      default:     w_state_nxt = HZ_RUN;
    endcase
    if (rst_n) begin
      if (w_freeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (ex_redirect) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (w_load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd      <= '0;
      r_ex_rs1     <= '0;
      r_ex_rs2     <= '0;
      r_ex_rs1_use <= 1'b0;
      r_ex_rs2_use <= 1'b0;
      r_ex_regw    <= 1'b0;
      r_ex_ld      <= 1'b0;
      r_mem_rd     <= '0;
      r_mem_regw   <= 1'b0;
      r_mem_ld     <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_regw    <= 1'b0;
    end else if (!w_freeze) begin
      r_mem_rd   <= r_ex_rd;
      r_mem_regw <= r_ex_regw;
      r_mem_ld   <= r_ex_ld;
      r_wb_rd    <= r_mem_rd;
      r_wb_regw  <= r_mem_regw;
      if (w_bubble) begin
        r_ex_rd      <= '0;
        r_ex_rs1     <= '0;
        r_ex_rs2     <= '0;
        r_ex_rs1_use <= 1'b0;
        r_ex_rs2_use <= 1'b0;
        r_ex_regw    <= 1'b0;
        r_ex_ld      <= 1'b0;
      end else begin
        r_ex_rd      <= id_rd;
        r_ex_rs1     <= id_rs1;
        r_ex_rs2     <= id_rs2;
        r_ex_rs1_use <= id_rs1_use;
        r_ex_rs2_use <= id_rs2_use;
        r_ex_regw    <= id_regwrite;
        r_ex_ld      <= id_mem2reg;
      end
    end
  end

  // Counter saturates at WAIT_MAX; the flag is set on the edge it gets there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_freeze) begin
      if (r_wait_cnt != WAIT_W'(WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // A load sitting in MEM can never be the forwarding source
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(r_mem_ld && ((fwd_a == FWD_MEM) || (fwd_b == FWD_MEM))));

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_use = 0, id_rs2_use = 0, id_regwrite = 0, id_mem2reg = 0;
  logic       ex_redirect = 0, mem_req = 0, mem_ack = 0;
  logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, dmem_timeout;
  logic [1:0] fwd_a, fwd_b;

  int n_pass = 0;
  int n_total = 0;
  logic rst_drv = 1'b0;

  hazard_ctrl #(.RA_W(5), .WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_mem2reg(id_mem2reg),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_timeout(dmem_timeout)
  );

  always #5 clk = ~clk;

  // Instruction-level model: what sits in EX, MEM and WB
  typedef struct packed {
    logic       valid;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, regw, ld;
  } ins_t;

  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  int   m_run = 0;
  bit   m_to = 0;
  bit   m_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit writes(input ins_t p, input logic [4:0] r);
    return p.valid && p.regw && (p.rd != 0) && (p.rd == r);
  endfunction

  // Youngest older producer wins: distance 1 -> MEM, distance 2 -> WB
  function automatic logic [1:0] src(input logic use_it, input logic [4:0] r);
    ins_t older[2];
    older[0] = m_mem;
    older[1] = m_wb;
    if (!use_it) return 2'd0;
    for (int i = 0; i < 2; i++)
      if (writes(older[i], r)) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic bit lu_now();
    if (!(m_ex.valid && m_ex.ld)) return 0;
    return (id_rs1_use && writes(m_ex, id_rs1)) || (id_rs2_use && writes(m_ex, id_rs2));
  endfunction

  always @(posedge clk) begin
    bit fz, lu;
    ins_t nx;
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_run = 0; m_to = 0; m_wait = 0;
    end else begin
      fz = mem_req && !mem_ack;
      lu = lu_now();
      if (m_wait) m_wait = !mem_ack;
      else        m_wait = fz;
      if (fz) begin
        m_run++;
        if (m_run >= 15) m_to = 1;
      end else begin
        m_run = 0;
        nx = '{valid: 1'b1, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
               u1: id_rs1_use, u2: id_rs2_use, regw: id_regwrite, ld: id_mem2reg};
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (ex_redirect || lu) ? ins_t'('0) : nx;
      end
    end
  end

  // Compare process: every negedge
  always @(negedge clk) begin
    logic [3:0] est;
    logic [1:0] efl, ea, eb;
    logic       eto, ews;
    est = '0; efl = '0; ea = 0; eb = 0; eto = 0; ews = 0;
    if (rst_n) begin
      if (mem_req && !mem_ack) est = 4'b1111;
      else if (ex_redirect)    efl = 2'b11;
      else if (lu_now()) begin est = 4'b0011; efl = 2'b01; end
      ea  = src(m_ex.u1, m_ex.rs1);
      eb  = src(m_ex.u2, m_ex.rs2);
      eto = m_to;
      ews = m_wait;
    end
    check("stall_if",  32'(stall_if),  32'(est[0]));
    check("stall_id",  32'(stall_id),  32'(est[1]));
    check("stall_ex",  32'(stall_ex),  32'(est[2]));
    check("stall_mem", 32'(stall_mem), 32'(est[3]));
    check("flush_ex",  32'(flush_ex),  32'(efl[0]));
    check("flush_id",  32'(flush_id),  32'(efl[1]));
    check("fwd_a", 32'(fwd_a), 32'(ea));
    check("fwd_b", 32'(fwd_b), 32'(eb));
    check("dmem_timeout", 32'(dmem_timeout), 32'(eto));
    check("fsm_wait", 32'(dut.r_state == HZ_MEM_WAIT), 32'(ews));
  end

  task automatic cyc(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic ld,
                     input logic rdr, input logic req, input logic ack);
    @(posedge clk);
    #1;
    rst_n = rst_drv;
    id_rs1 = r1; id_rs1_use = u1; id_rs2 = r2; id_rs2_use = u2;
    id_rd = rd; id_regwrite = rw; id_mem2reg = ld;
    ex_redirect = rdr; mem_req = req; mem_ack = ack;
    @(negedge clk);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [4:0] regs [5] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd7};

  initial begin
    // reset with hostile inputs: everything must read zero
    rst_drv = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("lit_rst_stall_if", 32'(stall_if), 32'd0);
    check("lit_rst_flush_id", 32'(flush_id), 32'd0);
    rst_drv = 1;
    nop(); nop();

    // add x5 ; sub rs1=x5 -> MEM forward
    cyc(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    nop();
    check("lit_fwd_a_mem", 32'(fwd_a), 32'd1);
    check("lit_fwd_nostall", 32'(stall_if), 32'd0);

    // add x5 ; nop ; use rs2=x5 -> WB forward, then same with x0
    cyc(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    nop();
    cyc(0, 0, 5, 1, 9, 1, 0, 0, 0, 0);
    nop();
    check("lit_fwd_b_wb", 32'(fwd_b), 32'd2);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    nop();
    cyc(0, 0, 0, 1, 9, 1, 0, 0, 0, 0);
    nop();
    check("lit_fwd_b_x0", 32'(fwd_b), 32'd0);

    // lw x7 ; use rs1=x7 -> one bubble, then WB forward
    cyc(0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    cyc(7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    check("lit_lu_stall_if", 32'(stall_if), 32'd1);
    check("lit_lu_flush_ex", 32'(flush_ex), 32'd1);
    check("lit_lu_stall_ex", 32'(stall_ex), 32'd0);
    cyc(7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    check("lit_lu_once", 32'(stall_if), 32'd0);
    nop();
    check("lit_lu_fwd_a", 32'(fwd_a), 32'd2);

    // load-use coinciding with a redirect: redirect wins
    cyc(0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    cyc(7, 1, 0, 0, 8, 1, 0, 1, 0, 0);
    check("lit_rdr_flush_id", 32'(flush_id), 32'd1);
    check("lit_rdr_flush_ex", 32'(flush_ex), 32'd1);
    check("lit_rdr_stall_if", 32'(stall_if), 32'd0);
    nop(); nop();

    // three wait cycles then ack
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("lit_wait_stall_mem", 32'(stall_mem), 32'd1);
      check("lit_wait_fsm", 32'(dut.r_state == HZ_MEM_WAIT), 32'(k > 1));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("lit_ack_stall_if", 32'(stall_if), 32'd0);
    nop();
    check("lit_ack_fsm_run", 32'(dut.r_state == HZ_MEM_WAIT), 32'd0);

    // long wait -> sticky timeout, then reset mid-wait
    for (int k = 1; k <= 18; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (k == 14) check("lit_to_early", 32'(dmem_timeout), 32'd0);
      if (k == 16) check("lit_to_set", 32'(dmem_timeout), 32'd1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("lit_to_sticky", 32'(dmem_timeout), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_drv = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("lit_rst_mid_stall", 32'(stall_mem), 32'd0);
    check("lit_rst_mid_to", 32'(dmem_timeout), 32'd0);
    check("lit_rst_mid_fsm", 32'(dut.r_state == HZ_MEM_WAIT), 32'd0);
    rst_drv = 1;
    nop();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic req;
      req = ($urandom_range(0, 3) == 0);
      rst_drv = ($urandom_range(0, 599) != 0);
      cyc(regs[$urandom_range(0, 4)], 1'($urandom), regs[$urandom_range(0, 4)], 1'($urandom),
          regs[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0), req, req && ($urandom_range(0, 2) != 0));
    end
    rst_drv = 1;
    nop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
